// File: rtl/bootrom_arbiter_if.sv
// Signal bundle between the CPU/host requesters, the boot ROM pins and bootrom_arbiter.
// Handshake: a requester raises req with stable we/addr/wdata and keeps it high until it sees a
// one-cycle ack; rdata/err are valid only with ack, and a req still high after ack counts as a new request.
interface bootrom_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_err;

    logic        host_req;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        host_err;

    logic        rom_cs;
    logic        rom_we;
    logic [3:0]  rom_addr;
    logic [15:0] rom_din;
    logic [15:0] rom_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_err,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_err,
        output rom_cs, rom_we, rom_addr, rom_din,
        input  rom_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_err,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_err,
        input  rom_cs, rom_we, rom_addr, rom_din,
        output rom_dout
    );
endinterface

// File: rtl/bootrom_arbiter.sv
// Round-robin CPU/host arbiter for the 16-word boot ROM with per-word write protection.
// Every output is a register; the ROM pins are loaded on the grant edge, the ack one cycle after ACCESS ends.
module bootrom_arbiter #(
    parameter logic [15:0] WRITABLE_MASK = 16'h0080
) (
    input  logic             romclk,
    input  logic             rst,
    bootrom_arbiter_if.slave bus,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic CPU  = 1'b0;
    localparam logic HOST = 1'b1;

    state_t      state;
    state_t      state_nxt;

    logic        last;
    logic        owner;
    logic        cmd_we;
    logic [3:0]  cmd_addr;
    logic        err_flag;
    logic [15:0] resp_data;

    logic        any_req;
    logic        winner;
    logic        win_we;
    logic [3:0]  win_addr;
    logic [15:0] win_wdata;
    logic        win_ok;

    logic        load_cmd;
    logic        capture;
    logic        rom_cs_nxt;
    logic        rom_we_nxt;
    logic [3:0]  rom_addr_nxt;
    logic [15:0] rom_din_nxt;
    logic        cpu_ack_nxt;
    logic        cpu_err_nxt;
    logic [15:0] cpu_rdata_nxt;
    logic        host_ack_nxt;
    logic        host_err_nxt;
    logic [15:0] host_rdata_nxt;

    // On a tie the port that was not served last wins.
    always_comb begin : arbitrate
        any_req = bus.cpu_req | bus.host_req;
        if (bus.cpu_req && bus.host_req) begin
            winner = ~last;
        end else if (bus.host_req) begin
            winner = HOST;
        end else begin
            winner = CPU;
        end
        win_we    = (winner == HOST) ? bus.host_we    : bus.cpu_we;
        win_addr  = (winner == HOST) ? bus.host_addr  : bus.cpu_addr;
        win_wdata = (winner == HOST) ? bus.host_wdata : bus.cpu_wdata;
        win_ok    = ~win_we | WRITABLE_MASK[win_addr];
    end

    always_ff @(posedge romclk or posedge rst) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : fsm_next
        state_nxt      = state;
        load_cmd       = 1'b0;
        capture        = 1'b0;
        rom_cs_nxt     = 1'b0;
        rom_we_nxt     = 1'b0;
        rom_addr_nxt   = 4'd0;
        rom_din_nxt    = 16'd0;
        cpu_ack_nxt    = 1'b0;
        cpu_err_nxt    = 1'b0;
        cpu_rdata_nxt  = 16'd0;
        host_ack_nxt   = 1'b0;
        host_err_nxt   = 1'b0;
        host_rdata_nxt = 16'd0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt    = ACCESS;
                    load_cmd     = 1'b1;
                    // A protected write keeps the chip deselected so the ROM never sees it.
                    rom_cs_nxt   = win_ok;
                    rom_we_nxt   = win_we & win_ok;
                    rom_addr_nxt = win_addr;
                    rom_din_nxt  = (win_we && win_ok) ? win_wdata : 16'd0;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                capture   = 1'b1;
            end
            RESP: begin
                state_nxt      = IDLE;
                cpu_ack_nxt    = (owner == CPU);
                cpu_err_nxt    = (owner == CPU) & err_flag;
                cpu_rdata_nxt  = (owner == CPU) ? resp_data : 16'd0;
                host_ack_nxt   = (owner == HOST);
                host_err_nxt   = (owner == HOST) & err_flag;
                host_rdata_nxt = (owner == HOST) ? resp_data : 16'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge romclk or posedge rst) begin : datapath
        if (rst) begin
            last           <= HOST;
            owner          <= CPU;
            cmd_we         <= 1'b0;
            cmd_addr       <= 4'd0;
            err_flag       <= 1'b0;
            resp_data      <= 16'd0;
            bus.rom_cs     <= 1'b0;
            bus.rom_we     <= 1'b0;
            bus.rom_addr   <= 4'd0;
            bus.rom_din    <= 16'd0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.cpu_rdata  <= 16'd0;
            bus.host_ack   <= 1'b0;
            bus.host_err   <= 1'b0;
            bus.host_rdata <= 16'd0;
        end else begin
            if (load_cmd) begin
                owner    <= winner;
                last     <= winner;
                cmd_we   <= win_we;
                cmd_addr <= win_addr;
            end
            if (capture) begin
                resp_data <= cmd_we ? 16'd0 : bus.rom_dout;
                err_flag  <= cmd_we & ~WRITABLE_MASK[cmd_addr];
            end
            bus.rom_cs     <= rom_cs_nxt;
            bus.rom_we     <= rom_we_nxt;
            bus.rom_addr   <= rom_addr_nxt;
            bus.rom_din    <= rom_din_nxt;
            bus.cpu_ack    <= cpu_ack_nxt;
            bus.cpu_err    <= cpu_err_nxt;
            bus.cpu_rdata  <= cpu_rdata_nxt;
            bus.host_ack   <= host_ack_nxt;
            bus.host_err   <= host_err_nxt;
            bus.host_rdata <= host_rdata_nxt;
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: directed scenarios followed by random single and tied accesses,
// checked against a word-level ROM model with a fixed 2-edge ack latency and alternating tie grants.
module tb_bootrom_arbiter;
    localparam logic [15:0] MASK = 16'h0080;
    localparam bit P_CPU  = 1'b0;
    localparam bit P_HOST = 1'b1;

    logic       romclk = 1'b0;
    logic       rst    = 1'b0;
    logic [1:0] dbg_state;

    bootrom_arbiter_if bus();

    bootrom_arbiter #(.WRITABLE_MASK(MASK)) dut (
        .romclk    (romclk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 romclk = ~romclk;

    // ROM stub: combinational read, write on the clock edge while cs and we are high.
    logic [15:0] rom_mem [16];
    logic [15:0] ref_mem [16];

    always @(posedge romclk) begin
        if (bus.rom_cs && bus.rom_we) rom_mem[bus.rom_addr] = bus.rom_din;
    end
    assign bus.rom_dout = (bus.rom_cs && !bus.rom_we) ? rom_mem[bus.rom_addr] : 16'hDEAD;

    logic [15:0] exp_q [$];
    int total = 0;
    int bad   = 0;
    bit m_last = P_HOST;

    function automatic logic [15:0] rom_init(input int i);
        logic [31:0] v;
        case (i)
            0: v = 32'hF200;
            1: v = 32'h4000;
            2: v = 32'hF800;
            3: v = 32'h1007;
            4: v = 32'hF400;
            5: v = 32'h3007;
            6: v = 32'h4000;
            7: v = 32'h7E57;
            default: v = 32'h1111 * i;
        endcase
        return v[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference: protected writes are dropped with err, reads return current contents, writes yield rdata 0.
    task automatic model_access(input bit we, input logic [3:0] a, input logic [15:0] d,
                                output logic [15:0] rdata, output logic err);
        logic [15:0] mask_v;
        mask_v = MASK;
        err    = we && !mask_v[a];
        rdata  = we ? 16'd0 : ref_mem[a];
        if (we && !err) ref_mem[a] = d;
    endtask

    task automatic set_port(input bit p, input bit req, input bit we, input logic [3:0] a,
                            input logic [15:0] d);
        if (p == P_HOST) begin
            bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    function automatic logic [57:0] all_outputs();
        return {bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.host_ack, bus.host_rdata, bus.host_err,
                bus.rom_cs, bus.rom_we, bus.rom_addr, bus.rom_din};
    endfunction

    task automatic check_pins(input bit we, input logic [3:0] a, input logic [15:0] d, input bit ee);
        chk("rom_cs", bus.rom_cs, !ee);
        chk("rom_we", bus.rom_we, we && !ee);
        chk("rom_addr", bus.rom_addr, a);
        chk("rom_din", bus.rom_din, (we && !ee) ? d : 16'd0);
    endtask

    task automatic check_idle_cycle();
        chk("no_ack", {bus.host_ack, bus.cpu_ack}, 2'b00);
    endtask

    task automatic check_ack(input bit p, input bit ee);
        logic [15:0] want;
        chk("ack_owner", {bus.host_ack, bus.cpu_ack}, p ? 2'b10 : 2'b01);
        chk("ack_pins_off", {bus.rom_cs, bus.rom_we}, 2'b00);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
            want = 16'd0;
        end else begin
            want = exp_q.pop_front();
        end
        chk("rdata", p ? bus.host_rdata : bus.cpu_rdata, want);
        chk("err", p ? bus.host_err : bus.cpu_err, ee);
        chk("other_rdata_err", p ? {bus.cpu_rdata, bus.cpu_err} : {bus.host_rdata, bus.host_err}, 17'd0);
    endtask

    task automatic single(input bit p, input bit we, input logic [3:0] a, input logic [15:0] d);
        logic [15:0] er;
        logic        ee;
        model_access(we, a, d, er, ee);
        exp_q.push_back(er);
        m_last = p;
        @(negedge romclk);
        set_port(p, 1'b1, we, a, d);
        @(posedge romclk); @(negedge romclk);
        check_pins(we, a, d, ee);
        check_idle_cycle();
        @(posedge romclk); @(negedge romclk);
        chk("resp_pins_off", {bus.rom_cs, bus.rom_we, bus.rom_addr, bus.rom_din}, 22'd0);
        check_idle_cycle();
        @(posedge romclk); @(negedge romclk);
        check_ack(p, ee);
        set_port(p, 1'b0, we, a, d);
    endtask

    // Both ports raise req together; the winner is the port not served last, the loser 3 cycles later.
    task automatic pair(input bit we_c, input logic [3:0] a_c, input logic [15:0] d_c,
                        input bit we_h, input logic [3:0] a_h, input logic [15:0] d_h);
        bit          w;
        bit          l;
        logic [15:0] er_w, er_l;
        logic        ee_w, ee_l;
        w = ~m_last;
        l = ~w;
        model_access(w ? we_h : we_c, w ? a_h : a_c, w ? d_h : d_c, er_w, ee_w);
        model_access(l ? we_h : we_c, l ? a_h : a_c, l ? d_h : d_c, er_l, ee_l);
        exp_q.push_back(er_w);
        exp_q.push_back(er_l);
        @(negedge romclk);
        set_port(P_CPU, 1'b1, we_c, a_c, d_c);
        set_port(P_HOST, 1'b1, we_h, a_h, d_h);
        for (int i = 0; i < 6; i++) begin
            @(posedge romclk); @(negedge romclk);
            chk("never_both_ack", bus.cpu_ack & bus.host_ack, 1'b0);
            if (i == 0) check_pins(w ? we_h : we_c, w ? a_h : a_c, w ? d_h : d_c, ee_w);
            if (i == 3) check_pins(l ? we_h : we_c, l ? a_h : a_c, l ? d_h : d_c, ee_l);
            if (i == 2) begin
                check_ack(w, ee_w);
                set_port(w, 1'b0, 1'b0, 4'd0, 16'd0);
            end else if (i == 5) begin
                check_ack(l, ee_l);
                set_port(l, 1'b0, 1'b0, 4'd0, 16'd0);
            end else begin
                check_idle_cycle();
            end
        end
        m_last = l;
    endtask

    task automatic continuous(input logic [3:0] a_c, input logic [3:0] a_h, input int grants);
        bit          w;
        bit          p;
        logic [15:0] er;
        logic        ee;
        w = ~m_last;
        @(negedge romclk);
        set_port(P_CPU, 1'b1, 1'b0, a_c, 16'd0);
        set_port(P_HOST, 1'b1, 1'b0, a_h, 16'd0);
        for (int i = 0; i < 3 * grants; i++) begin
            @(posedge romclk); @(negedge romclk);
            chk("never_both_ack", bus.cpu_ack & bus.host_ack, 1'b0);
            if (i % 3 == 2) begin
                p = w ^ (((i / 3) % 2) == 1);
                model_access(1'b0, p ? a_h : a_c, 16'd0, er, ee);
                exp_q.push_back(er);
                check_ack(p, ee);
                m_last = p;
            end else begin
                check_idle_cycle();
            end
        end
        set_port(P_CPU, 1'b0, 1'b0, 4'd0, 16'd0);
        set_port(P_HOST, 1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    initial begin
        logic [15:0] er;
        logic        ee;
        for (int i = 0; i < 16; i++) begin
            rom_mem[i] = rom_init(i);
            ref_mem[i] = rom_init(i);
        end
        set_port(P_CPU, 1'b0, 1'b0, 4'd0, 16'd0);
        set_port(P_HOST, 1'b0, 1'b0, 4'd0, 16'd0);

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", all_outputs(), 58'd0);
        chk("reset_state", dbg_state, 2'd0);
        repeat (2) @(negedge romclk);
        rst = 1'b0;

        // Directed scenarios
        single(P_CPU, 1'b0, 4'd0, 16'd0);
        single(P_HOST, 1'b1, 4'd7, 16'hA5A5);
        single(P_CPU, 1'b0, 4'd7, 16'd0);
        single(P_HOST, 1'b1, 4'd3, 16'hFFFF);
        single(P_CPU, 1'b0, 4'd3, 16'd0);
        single(P_HOST, 1'b0, 4'd0, 16'd0);
        continuous(4'd1, 4'd5, 3);

        // Reset in the middle of a CPU read: outputs clear at once and no ack follows
        @(negedge romclk);
        set_port(P_CPU, 1'b1, 1'b0, 4'd2, 16'd0);
        @(posedge romclk); @(negedge romclk);
        chk("pre_reset_cs", bus.rom_cs, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", all_outputs(), 58'd0);
        chk("async_reset_state", dbg_state, 2'd0);
        @(posedge romclk); @(negedge romclk);
        check_idle_cycle();
        set_port(P_CPU, 1'b0, 1'b0, 4'd0, 16'd0);
        @(posedge romclk); @(negedge romclk);
        check_idle_cycle();
        rst = 1'b0;
        m_last = P_HOST;
        single(P_CPU, 1'b0, 4'd2, 16'd0);

        // Back-to-back CPU reads with req held across the first ack
        model_access(1'b0, 4'd4, 16'd0, er, ee);
        exp_q.push_back(er);
        model_access(1'b0, 4'd6, 16'd0, er, ee);
        exp_q.push_back(er);
        @(negedge romclk);
        set_port(P_CPU, 1'b1, 1'b0, 4'd4, 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge romclk); @(negedge romclk);
            if (i == 0) check_pins(1'b0, 4'd4, 16'd0, 1'b0);
            if (i == 3) check_pins(1'b0, 4'd6, 16'd0, 1'b0);
            if (i == 2) begin
                check_ack(P_CPU, 1'b0);
                set_port(P_CPU, 1'b1, 1'b0, 4'd6, 16'd0);
            end else if (i == 5) begin
                check_ack(P_CPU, 1'b0);
                set_port(P_CPU, 1'b0, 1'b0, 4'd0, 16'd0);
            end else begin
                check_idle_cycle();
            end
        end
        m_last = P_CPU;

        // Random traffic: writes lean toward the patchable word so reads see fresh data
        for (int k = 0; k < 40; k++) begin
            bit          we0, we1;
            logic [3:0]  a0, a1;
            logic [15:0] d0, d1;
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            a0  = ($urandom_range(0, 1) == 1) ? 4'd7 : 4'($urandom_range(0, 15));
            a1  = ($urandom_range(0, 1) == 1) ? 4'd7 : 4'($urandom_range(0, 15));
            d0  = 16'($urandom);
            d1  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                pair(we0, a0, d0, we1, a1, d1);
            end else begin
                single(1'($urandom_range(0, 1)), we0, a0, d0);
            end
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
